lsu_bank_arbiter: RTL and testbench
===================================

# lsu_bank_arbiter

Round-robin arbiter that shares one single-port synchronous SRAM bank among several LSU requesters. Each cycle it grants at most one pending read or write, issues it to the bank through a registered port, and routes read data back to the winning requester with a one-hot response strobe. It sits between the LSU array's read/write request outputs and each data-memory bank, and its response path feeds the LSU load path.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `A_W`, 16: bank word-address width.
- `D_W`, 32: data width.

- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester request pending.
- `req_we` in NUM_REQ: 1 = write, 0 = read.
- `req_addr` in NUM_REQ*A_W: packed addresses; requester i at [i*A_W +: A_W].
- `req_wdata` in NUM_REQ*D_W: packed write data; requester i at [i*D_W +: D_W].
- `stall` in 1: freezes arbitration; no new grants while high.
- `gnt` out NUM_REQ: one-hot grant, combinational, same cycle as the accepted request.
- `rsp_valid` out NUM_REQ: one-hot read-data strobe.
- `rsp_data` out D_W: read data broadcast to all requesters; qualified by `rsp_valid`.
- `mem_en` out 1: bank access enable, registered.
- `mem_we` out 1: bank write enable, registered.
- `mem_addr` out A_W: bank address, registered.
- `mem_wdata` out D_W: bank write data, registered.
- `mem_rdata` in D_W: bank read data, valid the cycle after a read `mem_en`.

## Operation
- Handshake:
  - A requester raises `req_valid` and holds `req_we`, `req_addr` and `req_wdata` stable until it sees `gnt[i]=1`.
  - The request is consumed in the grant cycle.
  - The requester may present a new request in the following cycle.
- Arbitration:
  - Register `ptr` (log2 NUM_REQ bits).
  - Search eligible requesters starting at `ptr` and wrap modulo NUM_REQ. The first valid one wins.
  - On a grant to requester k, `ptr <= (k+1) mod NUM_REQ`.
  - With no grant, `ptr` holds.
- Eligible set: all `req_valid` bits. See Configuration for the write-priority variant.
- `stall=1` forces `gnt=0` and holds `ptr`. Accesses already issued still complete and still return their responses.
- Issue stage: in the cycle after the grant, `mem_en=1` and `mem_we=req_we[k]`, with `mem_addr` and `mem_wdata` taken from requester k. When there is no grant, `mem_en=0` and `mem_we=0`; address and data hold their last values.
- Response tag:
  - A read issue stores a one-hot tag for k. Write issues store no tag.
  - One cycle after the issue, `rsp_valid` equals that tag and `rsp_data=mem_rdata`.
  - `rsp_valid` is all-zero otherwise.
- Throughput is one access per cycle, back-to-back, with no bubbles.
- Reset values: `ptr=0`, `mem_en=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, tag=0, `rsp_valid=0`. `gnt` is 0 whenever `req_valid=0`.
- Reset asserted mid-operation drops in-flight accesses and responses immediately. No response is produced after `rst_n` rises.

## Timing
- Cycle T: `req_valid[k]` is high and k wins, so `gnt[k]=1` in T.
- T+1: `mem_en`, `mem_we`, `mem_addr` and `mem_wdata` are presented to the bank.
- T+2: for a read, `rsp_valid[k]=1` and `rsp_data` is the bank word.
- Read latency from grant to data is 2 cycles. A write completes at T+1 with no response.
- Single request while the pointer is elsewhere: it is granted in the same cycle, so a lone requester is never starved.
- Worst-case wait for a continuously requesting requester is NUM_REQ-1 grants, excluding stall cycles.
- `gnt` combinationally depends only on `req_valid`, `req_we`, `stall` and `ptr`. It has no path from `mem_rdata`.

## Configuration
- Macro: `LSU_ARB_WRITE_PRIORITY_EN`.
- Defined:
  - If any valid request has `req_we=1`, only write requesters are eligible. Round-robin from `ptr` applies within that set.
  - Reads are eligible only in cycles with no pending write.
  - `ptr` still updates to k+1.
- Undefined: pure round-robin over all valid requesters, with reads and writes treated equally.

## Test plan
- Reset and single read:
  - During reset, all outputs are 0.
  - After reset, requester 2 reads address 0x0010 with the bank word 0xDEADBEEF: `gnt=0100` at T, `mem_addr=0x0010` and `mem_en=1` at T+1, `rsp_valid=0100` and `rsp_data=0xDEADBEEF` at T+2.
- Round-robin fairness: all four requesters read continuously for 8 cycles -> grants in order 0,1,2,3,0,1,2,3 with `mem_en=1` on every cycle from T+1.
- Write then read to the same address:
  - Requester 1 writes 0x12345678 to 0x0004.
  - Requester 1 then reads 0x0004 -> `rsp_data=0x12345678`, and no `rsp_valid` pulse for the write.
- Stall:
  - With requesters 0 and 3 pending, hold `stall=1` for 3 cycles -> `gnt=0` and `ptr` unchanged.
  - An in-flight read still returns.
  - After release, the grant goes to the requester at or after the held `ptr`.
- Write priority, macro defined:
  - Requester 0 reads while requester 3 writes -> `gnt=1000` first, then `gnt=0001`.
  - With the macro undefined -> `gnt=0001` first.
- Reset mid-flight: assert `rst_n=0` in the cycle after a read grant -> `rsp_valid` stays 0 for all cycles after the reset is released.

Source files
------------

// File: rtl/lsu_bank_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM bank among NUM_REQ LSU requesters; grant is same-cycle, bank port T+1, read data T+2.
// No backpressure from the bank; stall_i blocks new grants only. LSU_ARB_WRITE_PRIORITY_EN restricts eligibility to writers when any write is pending.
module lsu_bank_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int A_W     = 16,
   parameter int D_W     = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid_i,
   input  logic [NUM_REQ-1:0]     req_we_i,
   input  logic [NUM_REQ*A_W-1:0] req_addr_i,
   input  logic [NUM_REQ*D_W-1:0] req_wdata_i,
   input  logic                   stall_i,
   output logic [NUM_REQ-1:0]     gnt_o,
   output logic [NUM_REQ-1:0]     rsp_valid_o,
   output logic [D_W-1:0]         rsp_data_o,
   output logic                   mem_en_o,
   output logic                   mem_we_o,
   output logic [A_W-1:0]         mem_addr_o,
   output logic [D_W-1:0]         mem_wdata_o,
   input  logic [D_W-1:0]         mem_rdata_i
);

   localparam int PTR_W = $clog2(NUM_REQ);

   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic               mem_en_q, mem_en_d;
   logic               mem_we_q, mem_we_d;
   logic [A_W-1:0]     mem_addr_q, mem_addr_d;
   logic [D_W-1:0]     mem_wdata_q, mem_wdata_d;
   logic [NUM_REQ-1:0] tag_q, tag_d;
   logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;

   logic [NUM_REQ-1:0] elig;
   logic               found;
   logic [PTR_W-1:0]   win_idx;
   logic [PTR_W-1:0]   cand_idx;
   logic [NUM_REQ-1:0] win_oh;
   logic               gnt_any;
   logic               win_we;
   logic [A_W-1:0]     win_addr;
   logic [D_W-1:0]     win_wdata;

`ifdef LSU_ARB_WRITE_PRIORITY_EN
   logic [NUM_REQ-1:0] wr_pend;
   assign wr_pend = req_valid_i & req_we_i;
   assign elig    = (|wr_pend) ? wr_pend : req_valid_i;
`else
   assign elig    = req_valid_i;
`endif

   // First eligible requester at or after ptr, wrapping modulo NUM_REQ.
   always_comb begin
      found    = 1'b0;
      win_idx  = '0;
      cand_idx = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         cand_idx = PTR_W'((int'(ptr_q) + off) % NUM_REQ);
         if (!found && elig[cand_idx]) begin
            found   = 1'b1;
            win_idx = cand_idx;
         end
      end
   end

   assign gnt_any = found & ~stall_i;
   assign win_oh  = NUM_REQ'(1) << win_idx;
   assign gnt_o   = gnt_any ? win_oh : '0;

   always_comb begin
      win_we    = 1'b0;
      win_addr  = '0;
      win_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_oh[i]) begin
            win_we    = req_we_i[i];
            win_addr  = req_addr_i[i*A_W +: A_W];
            win_wdata = req_wdata_i[i*D_W +: D_W];
         end
      end
   end

   always_comb begin
      ptr_d       = ptr_q;
      mem_en_d    = gnt_any;
      mem_we_d    = gnt_any & win_we;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      tag_d       = '0;
      rsp_valid_d = tag_q;
      if (gnt_any) begin
         ptr_d       = (win_idx == PTR_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
         mem_addr_d  = win_addr;
         mem_wdata_d = win_wdata;
         // Only reads expect data back, so writes leave the tag empty.
         tag_d       = win_we ? '0 : win_oh;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         tag_q       <= '0;
         rsp_valid_q <= '0;
      end else begin
         ptr_q       <= ptr_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         tag_q       <= tag_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign mem_en_o    = mem_en_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = (|rsp_valid_q) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_lsu_bank_arbiter.sv
// Bench for lsu_bank_arbiter: directed scenarios plus randomized traffic against a transaction-level model with a behavioural bank.
module tb_lsu_bank_arbiter;
   localparam int N  = 4;
   localparam int AW = 16;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]    req_valid, req_we, gnt, rsp_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic            stall;
   logic [DW-1:0]   rsp_data, mem_wdata, mem_rdata;
   logic            mem_en, mem_we;
   logic [AW-1:0]   mem_addr;

   lsu_bank_arbiter #(.NUM_REQ(N), .A_W(AW), .D_W(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid), .req_we_i(req_we),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .stall_i(stall),
      .gnt_o(gnt), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
      .mem_en_o(mem_en), .mem_we_o(mem_we),
      .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata)
   );

   function automatic logic [DW-1:0] init_val(input int a);
      if (a == 16) return 32'hDEADBEEF;
      return 32'hA5000000 ^ DW'(a * 32'h01010101);
   endfunction

   // Behavioural single-port bank: data appears the cycle after a read enable.
   logic [DW-1:0] bank [256];
   bit            bw   [256];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            bank[mem_addr[7:0]] <= mem_wdata;
            bw[mem_addr[7:0]]   <= 1'b1;
         end else begin
            mem_rdata <= bw[mem_addr[7:0]] ? bank[mem_addr[7:0]] : init_val(int'(mem_addr[7:0]));
         end
      end
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Requester state and transaction-level model.
   bit            rv [N];
   bit            rw [N];
   logic [AW-1:0] ra [N];
   logic [DW-1:0] rd [N];
   bit            stall_m;

   typedef struct {
      bit            vld;
      bit            we;
      int            k;
      logic [DW-1:0] data;
   } ev_t;

   ev_t           p1, p2;
   int            ptr_m;
   logic [AW-1:0] last_a;
   logic [DW-1:0] last_d;
   logic [DW-1:0] refmem [int];

   logic [N-1:0]  obs_gnt, obs_rsp;
   logic          obs_en, obs_we;
   logic [AW-1:0] obs_addr;
   logic [DW-1:0] obs_rdata;

   function automatic logic [DW-1:0] ref_rd(input int a);
      return refmem.exists(a) ? refmem[a] : init_val(a);
   endfunction

   // Winner = eligible requester with the smallest forward distance from ptr.
   function automatic int pick();
      int best = -1;
      int bd = N;
`ifdef LSU_ARB_WRITE_PRIORITY_EN
      bit anyw = 1'b0;
      for (int i = 0; i < N; i++) if (rv[i] && rw[i]) anyw = 1'b1;
`endif
      if (stall_m) return -1;
      for (int i = 0; i < N; i++) begin
         bit e = rv[i];
`ifdef LSU_ARB_WRITE_PRIORITY_EN
         if (anyw) e = rv[i] && rw[i];
`endif
         if (e && ((i - ptr_m + N) % N) < bd) begin
            bd   = (i - ptr_m + N) % N;
            best = i;
         end
      end
      return best;
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i]           = rv[i];
         req_we[i]              = rw[i];
         req_addr[i*AW +: AW]   = ra[i];
         req_wdata[i*DW +: DW]  = rd[i];
      end
      stall = stall_m;
   endtask

   task automatic step();
      int g;
      logic [63:0] exp_r;
      drive();
      @(negedge clk);
      obs_gnt = gnt; obs_en = mem_en; obs_we = mem_we;
      obs_addr = mem_addr; obs_rsp = rsp_valid; obs_rdata = rsp_data;
      g = pick();
      chk("gnt", 64'(gnt), (g >= 0) ? (64'(1) << g) : 64'(0));
      chk("mem_en", 64'(mem_en), 64'(p1.vld));
      chk("mem_we", 64'(mem_we), 64'(p1.vld && p1.we));
      chk("mem_addr", 64'(mem_addr), 64'(last_a));
      chk("mem_wdata", 64'(mem_wdata), 64'(last_d));
      exp_r = (p2.vld && !p2.we) ? (64'(1) << p2.k) : 64'(0);
      chk("rsp_valid", 64'(rsp_valid), exp_r);
      if (exp_r != 0) chk("rsp_data", 64'(rsp_data), 64'(p2.data));
      p2 = p1;
      p1.vld = 1'b0; p1.we = 1'b0; p1.k = 0; p1.data = '0;
      if (g >= 0) begin
         p1.vld = 1'b1;
         p1.we  = rw[g];
         p1.k   = g;
         if (rw[g]) refmem[int'(ra[g][7:0])] = rd[g];
         else       p1.data = ref_rd(int'(ra[g][7:0]));
         last_a = ra[g];
         last_d = rd[g];
         ptr_m  = (g + 1) % N;
         rv[g]  = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) rv[i] = 1'b0;
      stall_m = 1'b0;
      drive();
      repeat (2) begin
         @(negedge clk);
         chk("rst_gnt", 64'(gnt), 64'(0));
         chk("rst_mem_en", 64'(mem_en), 64'(0));
         chk("rst_mem_we", 64'(mem_we), 64'(0));
         chk("rst_mem_addr", 64'(mem_addr), 64'(0));
         chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
         chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
         chk("rst_rsp_data", 64'(rsp_data), 64'(0));
      end
      rst_n = 1'b1;
      ptr_m = 0; p1.vld = 1'b0; p2.vld = 1'b0; last_a = '0; last_d = '0;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      rv[i] = 1'b1; rw[i] = we; ra[i] = a; rd[i] = d;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin rv[i] = 0; rw[i] = 0; ra[i] = '0; rd[i] = '0; end
      stall_m = 1'b0;
      p1.vld = 1'b0; p2.vld = 1'b0; p1.we = 0; p2.we = 0; p1.k = 0; p2.k = 0;
      p1.data = '0; p2.data = '0;
      do_reset();

      // Single read by requester 2.
      set_req(2, 1'b0, 16'h0010, 32'h0);
      step(); chk("rd_gnt", 64'(obs_gnt), 64'h4);
      step(); chk("rd_en", 64'(obs_en), 64'h1); chk("rd_addr", 64'(obs_addr), 64'h10);
      step(); chk("rd_rsp", 64'(obs_rsp), 64'h4); chk("rd_data", 64'(obs_rdata), 64'hDEADBEEF);
      step();

      // Round-robin fairness with all four requesters reading continuously.
      do_reset();
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < N; i++) if (!rv[i]) set_req(i, 1'b0, AW'(i + 32), 32'h0);
         step();
         chk("rr_gnt", 64'(obs_gnt), 64'(1) << (c % N));
         if (c > 0) chk("rr_en", 64'(obs_en), 64'h1);
      end
      for (int i = 0; i < N; i++) rv[i] = 1'b0;
      repeat (3) step();

      // Stall with requesters 0 and 3 pending and a read in flight.
      do_reset();
      set_req(1, 1'b0, 16'h0005, 32'h0);
      step();
      set_req(0, 1'b0, 16'h0006, 32'h0);
      set_req(3, 1'b0, 16'h0007, 32'h0);
      stall_m = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("stall_gnt", 64'(obs_gnt), 64'h0);
         if (c == 1) chk("stall_rsp", 64'(obs_rsp), 64'h2);
      end
      stall_m = 1'b0;
      step(); chk("unstall_gnt", 64'(obs_gnt), 64'h8);
      step(); chk("unstall_gnt2", 64'(obs_gnt), 64'h1);
      repeat (3) step();

      // Read from 0 competing with write from 3.
      do_reset();
      set_req(0, 1'b0, 16'h0007, 32'h0);
      set_req(3, 1'b1, 16'h0009, 32'hCAFEF00D);
      step();
`ifdef LSU_ARB_WRITE_PRIORITY_EN
      chk("wp_first", 64'(obs_gnt), 64'h8);
      step(); chk("wp_second", 64'(obs_gnt), 64'h1);
`else
      chk("wp_first", 64'(obs_gnt), 64'h1);
      step(); chk("wp_second", 64'(obs_gnt), 64'h8);
`endif
      repeat (3) step();

      // Write then read back the same address.
      do_reset();
      set_req(1, 1'b1, 16'h0004, 32'h12345678);
      step();
      set_req(1, 1'b0, 16'h0004, 32'h0);
      step(); chk("wr_en", 64'(obs_en), 64'h1); chk("wr_we", 64'(obs_we), 64'h1);
      step(); chk("wr_no_rsp", 64'(obs_rsp), 64'h0); chk("rb_we", 64'(obs_we), 64'h0);
      step(); chk("rb_rsp", 64'(obs_rsp), 64'h2); chk("rb_data", 64'(obs_rdata), 64'h12345678);
      step();

      // Reset in the cycle after a read grant.
      do_reset();
      set_req(2, 1'b0, 16'h0003, 32'h0);
      step();
      do_reset();
      for (int c = 0; c < 4; c++) begin
         step();
         chk("midrst_rsp", 64'(obs_rsp), 64'h0);
      end

      // Randomized traffic.
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++)
            if (!rv[i] && ($urandom % 3 == 0))
               set_req(i, 1'($urandom % 2), AW'($urandom % 16), $urandom);
         stall_m = ($urandom % 8 == 0);
         step();
      end
      stall_m = 1'b0;
      for (int i = 0; i < N; i++) rv[i] = 1'b0;
      repeat (3) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
